// File: rtl/transport_tx_framer.sv
// transport_tx_framer: buffers one payload burst and sends it as SYNC, addr, payload, check over valid/ready.
// Define TX_FRAMER_CRC8_EN to make the check byte CRC-8/0x07 instead of the inverted byte sum.
module transport_tx_framer #(
    parameter int         PAYLOAD_BYTES = 16,
    parameter logic [7:0] SYNC_BYTE     = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] phone_num,
    input  logic       sending,
    input  logic [7:0] packet_in,
    output logic       busy_out,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       frame_done,
    output logic       short_err,
    output logic       overrun
);
    localparam int CW = $clog2(PAYLOAD_BYTES) + 1;
    localparam int IW = $clog2(PAYLOAD_BYTES);
    localparam logic [CW-1:0] FULL = CW'(PAYLOAD_BYTES);
    localparam logic [CW-1:0] LAST = CW'(PAYLOAD_BYTES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SYNC, ADDR, PAYLOAD, CHECK, DONE} state_t;

    function automatic logic [7:0] chk_upd(input logic [7:0] c, input logic [7:0] b);
`ifdef TX_FRAMER_CRC8_EN
        logic [7:0] x;
        x = c ^ b;
        for (int i = 0; i < 8; i++) x = x[7] ? {x[6:0], 1'b0} ^ 8'h07 : {x[6:0], 1'b0};
        return x;
`else
        return c + b;
`endif
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    chk_q, chk_d;
    logic [7:0]    pay_q [PAYLOAD_BYTES];
    logic [IW-1:0] wr_idx;
    logic          buf_we;
    logic          sending_q;
    logic          overrun_q, overrun_d;
    logic          short_err_q, short_err_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic [7:0]    chk_out;
    logic          rise, acc;

`ifdef TX_FRAMER_CRC8_EN
    assign chk_out = chk_q;
`else
    assign chk_out = ~chk_q;
`endif

    assign rise = sending & ~sending_q;
    assign acc  = tx_valid_q & tx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            chk_q        <= '0;
            sending_q    <= 1'b0;
            overrun_q    <= 1'b0;
            short_err_q  <= 1'b0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            chk_q        <= chk_d;
            sending_q    <= sending;
            overrun_q    <= overrun_d;
            short_err_q  <= short_err_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Payload storage carries no reset: a discarded frame is simply overwritten.
    always_ff @(posedge clk) begin
        if (buf_we) pay_q[wr_idx] <= packet_in;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        chk_d       = chk_q;
        buf_we      = 1'b0;
        wr_idx      = cnt_q[IW-1:0];
        short_err_d = 1'b0;
        overrun_d   = overrun_q | (rise & (state_q != IDLE));
        case (state_q)
            IDLE: if (rise) begin
                state_d = LOAD;
                addr_d  = phone_num;
                chk_d   = chk_upd(chk_upd(8'h00, phone_num), packet_in);
                buf_we  = 1'b1;
                wr_idx  = '0;
                cnt_d   = CW'(1);
            end
            // Full buffer wins over a falling strobe; extra bytes of the same burst are dropped.
            LOAD: if (cnt_q == FULL) begin
                state_d = SYNC;
                cnt_d   = '0;
            end else if (!sending) begin
                state_d     = IDLE;
                cnt_d       = '0;
                short_err_d = 1'b1;
            end else begin
                buf_we = 1'b1;
                cnt_d  = cnt_q + CW'(1);
                chk_d  = chk_upd(chk_q, packet_in);
            end
            SYNC: if (acc) state_d = ADDR;
            ADDR: if (acc) state_d = PAYLOAD;
            PAYLOAD: if (acc) begin
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q == LAST) ? CHECK : PAYLOAD;
            end
            CHECK: if (acc) begin
                state_d = DONE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d       = state_d != IDLE;
        tx_valid_d   = state_d inside {SYNC, ADDR, PAYLOAD, CHECK};
        frame_done_d = state_d == DONE;
        tx_data_d    = state_d == SYNC    ? SYNC_BYTE :
                       state_d == ADDR    ? addr_d :
                       state_d == PAYLOAD ? pay_q[cnt_d[IW-1:0]] :
                       state_d == CHECK   ? chk_out : 8'h00;
    end

    assign busy_out   = busy_q;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign frame_done = frame_done_q;
    assign short_err  = short_err_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_transport_tx_framer.sv
// tb_transport_tx_framer: directed checks of framing, stalls, short bursts, overrun and reset for transport_tx_framer.
module tb_transport_tx_framer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sending = 1'b0;
    logic       tx_ready = 1'b0;
    logic [7:0] phone_num = 8'h00;
    logic [7:0] packet_in = 8'h00;
    logic       busy_out, tx_valid, frame_done, short_err, overrun;
    logic [7:0] tx_data;

    int         total = 0;
    int         bad = 0;
    int         first_v, last_a, got_n;
    logic [7:0] pay   [0:17];
    logic [7:0] exp_b [0:18];
    logic [7:0] got   [0:18];

    transport_tx_framer dut (
        .clk(clk), .reset(reset), .phone_num(phone_num), .sending(sending),
        .packet_in(packet_in), .busy_out(busy_out), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .frame_done(frame_done),
        .short_err(short_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    // Bit-serial CRC-8 (poly 0x07), shifting message bits MSB first.
    function automatic logic [7:0] crc_bits(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int b = 7; b >= 0; b--) begin
            fb = r[7] ^ d[b];
            r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return r;
    endfunction

    task automatic build_exp(input logic [7:0] a);
        logic [7:0] c;
`ifdef TX_FRAMER_CRC8_EN
        c = crc_bits(8'h00, a);
        for (int i = 0; i < 16; i++) c = crc_bits(c, pay[i]);
`else
        c = a;
        for (int i = 0; i < 16; i++) c = c + pay[i];
        c = ~c;
`endif
        exp_b[0] = 8'hA5;
        exp_b[1] = a;
        for (int i = 0; i < 16; i++) exp_b[i+2] = pay[i];
        exp_b[18] = c;
    endtask

    task automatic send_burst(input logic [7:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            sending   = 1'b1;
            packet_in = pay[i];
            phone_num = (i == 0) ? a : ~a;
        end
        @(posedge clk); #1;
        sending   = 1'b0;
        packet_in = 8'h00;
    endtask

    task automatic collect(input bit toggle, input int ovr_at);
        int         cyc = 0;
        bit         prev_stall = 1'b0;
        logic [7:0] prev_d = 8'h00;
        got_n   = 0;
        first_v = -1;
        last_a  = -1;
        while (got_n < 19 && cyc < 200) begin
            @(negedge clk);
            if (prev_stall) begin
                chk("stall_data", 32'(tx_data), 32'(prev_d));
                chk("stall_valid", 32'(tx_valid), 32'd1);
            end
            if (tx_valid && first_v < 0) first_v = cyc;
            if (tx_valid && tx_ready) begin
                got[got_n] = tx_data;
                got_n++;
                last_a = cyc;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_d     = tx_data;
            @(posedge clk); #1;
            cyc++;
            if (toggle) tx_ready = ~tx_ready;
            if (cyc == ovr_at) begin
                sending   = 1'b1;
                packet_in = 8'hEE;
            end
            if (cyc == ovr_at + 2) begin
                sending   = 1'b0;
                packet_in = 8'h00;
            end
        end
        chk("frame_len", 32'(got_n), 32'd19);
        for (int i = 0; i < 19; i++) chk($sformatf("byte%0d", i), 32'(got[i]), 32'(exp_b[i]));
    endtask

    task automatic post_frame();
        @(negedge clk);
        chk("done_pulse", 32'(frame_done), 32'd1);
        chk("done_busy", 32'(busy_out), 32'd1);
        @(negedge clk);
        chk("done_low", 32'(frame_done), 32'd0);
        chk("idle_busy", 32'(busy_out), 32'd0);
        chk("idle_valid", 32'(tx_valid), 32'd0);
    endtask

    initial begin
        int vseen;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_short", 32'(short_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);

        // Basic frame, ready always high; check byte 0x4D worked by hand.
        tx_ready = 1'b1;
        for (int i = 0; i < 18; i++) pay[i] = 8'(i + 1);
        build_exp(8'h2A);
        send_burst(8'h2A, 16);
        @(negedge clk);
        chk("lat_cycle16_valid", 32'(tx_valid), 32'd0);
        chk("lat_cycle16_busy", 32'(busy_out), 32'd1);
        collect(1'b0, -1);
        chk("lat_first_valid", 32'(first_v), 32'd0);
        chk("check_4d", 32'(got[18]), 32'h4D);
        post_frame();

        // Same frame with ready toggling, low on the first valid cycle.
        tx_ready = 1'b1;
        send_burst(8'h2A, 16);
        collect(1'b1, -1);
        chk("toggle_span", 32'(last_a - first_v + 1), 32'd38);
        tx_ready = 1'b1;
        post_frame();

        // Short burst of 5 bytes.
        send_burst(8'h33, 5);
        @(negedge clk);
        chk("short_pre", 32'(short_err), 32'd0);
        chk("short_pre_busy", 32'(busy_out), 32'd1);
        @(negedge clk);
        chk("short_pulse", 32'(short_err), 32'd1);
        chk("short_busy", 32'(busy_out), 32'd0);
        @(negedge clk);
        chk("short_end", 32'(short_err), 32'd0);
        vseen = 0;
        repeat (25) begin
            @(negedge clk);
            vseen += int'(tx_valid);
        end
        chk("short_novalid", 32'(vseen), 32'd0);

        // 18-byte burst with link stalled, then overrun injected during PAYLOAD.
        tx_ready = 1'b0;
        for (int i = 0; i < 18; i++) pay[i] = 8'(i * 17 + 3);
        build_exp(8'h5C);
        send_burst(8'h5C, 18);
        @(negedge clk);
        chk("long_no_ovr", 32'(overrun), 32'd0);
        chk("long_valid", 32'(tx_valid), 32'd1);
        chk("long_sync_held", 32'(tx_data), 32'hA5);
        @(posedge clk); #1;
        tx_ready = 1'b1;
        collect(1'b0, 6);
        chk("ovr_set", 32'(overrun), 32'd1);
        post_frame();
        repeat (5) @(negedge clk);
        chk("ovr_sticky", 32'(overrun), 32'd1);

        // Reset while payload byte 7 is on the bus.
        for (int i = 0; i < 16; i++) pay[i] = 8'(i * 7 + 8'h40);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            sending   = 1'b1;
            packet_in = pay[i];
            phone_num = 8'h77;
            reset     = (i == 7);
        end
        @(posedge clk); #1;
        reset   = 1'b0;
        sending = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(tx_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy_out), 32'd0);
        chk("mid_rst_ovr", 32'(overrun), 32'd0);
        build_exp(8'h77);
        send_burst(8'h77, 16);
        collect(1'b0, -1);
        post_frame();

        // All-zero payloads; addr 0 gives 0x00 under CRC-8 and 0xFF under the sum.
        for (int i = 0; i < 18; i++) pay[i] = 8'h00;
        build_exp(8'h00);
        send_burst(8'h00, 16);
        collect(1'b0, -1);
`ifdef TX_FRAMER_CRC8_EN
        chk("zero_check", 32'(got[18]), 32'h00);
`else
        chk("zero_check", 32'(got[18]), 32'hFF);
`endif
        post_frame();
        build_exp(8'h01);
        send_burst(8'h01, 16);
        collect(1'b0, -1);
        post_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
